// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - opcodes, state encoding and decode helper for control_sequencer
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_BZ   = 4'd7;
  localparam logic [3:0] OP_BN   = 4'd8;
  localparam logic [3:0] OP_BR   = 4'd9;
  localparam logic [3:0] OP_CALL = 4'd10;
  localparam logic [3:0] OP_RET  = 4'd11;
  localparam logic [3:0] OP_IN   = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;
  localparam logic [3:0] OP_RSVD = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_IMM      = 3'd1,
    S_EXEC     = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  // Opcodes that carry an immediate byte at the following address.
  function automatic logic is_two_word(input logic [3:0] opcode);
    return (opcode == OP_LDI) || (opcode == OP_BZ) || (opcode == OP_BN) ||
           (opcode == OP_BR)  || (opcode == OP_CALL);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - valid/ready input and output port bundle
interface control_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational ALU producing {Z, N, result}
module seq_alu
  import seq_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [9:0] res_o
);

  logic [7:0] result;

  // Carry and borrow fall off the top; LDI routes its immediate through b_i.
  always_comb begin
    result = 8'h00;
    case (op_i)
      OP_ADD:         result = a_i + b_i;
      OP_SUB:         result = a_i - b_i;
      OP_NAND:        result = ~(a_i & b_i);
      OP_SHL:         result = {a_i[6:0], 1'b0};
      OP_MOV, OP_LDI: result = b_i;
      default:        result = 8'h00;
    endcase
  end

  assign res_o = {(result == 8'h00), result[7], result};

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/execute sequencer driving the 4x8 register file
module control_sequencer
  import seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [7:0]                 imem_addr,
  input  logic [7:0]                 imem_data,
  output logic [1:0]                 ra,
  output logic [1:0]                 rb,
  output logic [9:0]                 wb,
  output logic [3:0]                 we,
  output logic [7:0]                 LRin,
  input  logic [7:0]                 raVal,
  input  logic [7:0]                 rbVal,
  input  logic                       N,
  input  logic                       Z,
  input  logic [7:0]                 LRout,
  control_sequencer_if.master        io,
  output logic                       halted
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] out_data_q, out_data_d;

  logic [3:0] opcode;
  logic [7:0] alu_b;
  logic [9:0] alu_res;

  assign opcode = ir_q[7:4];
  assign alu_b  = (opcode == OP_LDI) ? imm_q : rbVal;

  seq_alu u_alu (
    .op_i  (opcode),
    .a_i   (raVal),
    .b_i   (alu_b),
    .res_o (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      imm_q      <= 8'h00;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imm_q      <= imm_d;
      out_data_q <= out_data_d;
    end
  end

  // Write enables and write-back are held for the whole cycle so the
  // register file can sample them on the falling edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    out_data_d = out_data_q;
    we         = 4'b0000;
    wb         = 10'h000;
    LRin       = 8'h00;

    case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + 8'd1;
        state_d = is_two_word(imem_data[7:4]) ? S_IMM : S_EXEC;
      end

      S_IMM: begin
        imm_d   = imem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_MOV, OP_LDI: begin
            we = 4'b0111;
            wb = alu_res;
          end
          OP_BZ:   if (Z) pc_d = imm_q;
          OP_BN:   if (N) pc_d = imm_q;
          OP_BR:   pc_d = imm_q;
          OP_CALL: begin
            we   = 4'b1000;
            LRin = pc_q;
            pc_d = imm_q;
          end
          OP_RET:  pc_d = LRout;
          OP_IN:   state_d = S_IN_WAIT;
          OP_OUT: begin
            out_data_d = raVal;
            state_d    = S_OUT_WAIT;
          end
          OP_HALT: state_d = S_HALT;
          OP_NOP, OP_RSVD: state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end

      S_IN_WAIT: begin
        if (io.in_valid) begin
          we      = 4'b0001;
          wb      = {2'b00, io.in_data};
          state_d = S_FETCH;
        end
      end

      S_OUT_WAIT: begin
        if (io.out_ready) begin
          state_d = S_FETCH;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  assign imem_addr    = pc_q;
  assign ra           = ir_q[3:2];
  assign rb           = ir_q[1:0];
  assign io.in_ready  = (state_q == S_IN_WAIT);
  assign io.out_valid = (state_q == S_OUT_WAIT);
  assign io.out_data  = out_data_q;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [9:0] wb;
  logic [3:0] we;
  logic [7:0] LRin;
  logic [7:0] raVal;
  logic [7:0] rbVal;
  logic       N;
  logic       Z;
  logic [7:0] LRout;
  logic       halted;

  logic [7:0] imem [256];
  logic [7:0] gpr [4];
  logic       zf;
  logic       nf;
  logic [7:0] lr;

  int checks;
  int errors;

  control_sequencer_if io();

  control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ra        (ra),
    .rb        (rb),
    .wb        (wb),
    .we        (we),
    .LRin      (LRin),
    .raVal     (raVal),
    .rbVal     (rbVal),
    .N         (N),
    .Z         (Z),
    .LRout     (LRout),
    .io        (io),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];
  assign raVal     = gpr[ra];
  assign rbVal     = gpr[rb];
  assign Z         = zf;
  assign N         = nf;
  assign LRout     = lr;

  // Register file model: GPR and flags on the falling edge, LR on the rising edge.
  always @(negedge clk) begin
    if (we[0]) gpr[ra] <= wb[7:0];
    if (we[1]) zf <= wb[9];
    if (we[2]) nf <= wb[8];
  end

  always @(posedge clk) begin
    if (we[3]) lr <= LRin;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[8'(i)] = 8'hF0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = 8'h00;
    io.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_imem();
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = 8'h00;
    io.out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 8'h00); end
    checks++; if (we !== 4'b0000) begin errors++; $display("FAIL reset_we: got %b expected %b", we, 4'b0000); end
    checks++; if (wb !== 10'h000) begin errors++; $display("FAIL reset_wb: got %h expected %h", wb, 10'h000); end
    checks++; if (LRin !== 8'h00) begin errors++; $display("FAIL reset_lrin: got %h expected %h", LRin, 8'h00); end
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
    checks++; if (io.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", io.out_data); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if ({ra, rb} !== 4'b0000) begin errors++; $display("FAIL reset_ra_rb: got %b expected 0000", {ra, rb}); end
  endtask

  task automatic test_sub_zero();
    clear_imem();
    imem[8'h00] = 8'h64; imem[8'h01] = 8'h05;
    imem[8'h02] = 8'h68; imem[8'h03] = 8'h05;
    imem[8'h04] = 8'h26;
    do_reset();
    ticks(7);
    checks++; if (wb !== 10'h200) begin errors++; $display("FAIL sub_wb: got %h expected %h", wb, 10'h200); end
    checks++; if (we !== 4'b0111) begin errors++; $display("FAIL sub_we: got %b expected %b", we, 4'b0111); end
    tick();
    checks++; if (gpr[1] !== 8'h00) begin errors++; $display("FAIL sub_r1: got %h expected 00", gpr[1]); end
    checks++; if (zf !== 1'b1) begin errors++; $display("FAIL sub_zflag: got %b expected 1", zf); end
    checks++; if (imem_addr !== 8'h05) begin errors++; $display("FAIL sub_pc: got %h expected 05", imem_addr); end
  endtask

  task automatic test_alu();
    clear_imem();
    imem[8'h00] = 8'h60; imem[8'h01] = 8'hFF;
    imem[8'h02] = 8'h64; imem[8'h03] = 8'h01;
    imem[8'h04] = 8'h11;
    imem[8'h05] = 8'h68; imem[8'h06] = 8'h0F;
    imem[8'h07] = 8'h6C; imem[8'h08] = 8'hF0;
    imem[8'h09] = 8'h3B;
    imem[8'h0A] = 8'h4C;
    do_reset();
    ticks(7);
    checks++; if (wb !== 10'h200) begin errors++; $display("FAIL add_wrap_wb: got %h expected %h", wb, 10'h200); end
    ticks(8);
    checks++; if (wb !== 10'h1FF) begin errors++; $display("FAIL nand_wb: got %h expected %h", wb, 10'h1FF); end
    ticks(2);
    checks++; if (wb !== 10'h1E0) begin errors++; $display("FAIL shl_wb: got %h expected %h", wb, 10'h1E0); end
    checks++; if (we !== 4'b0111) begin errors++; $display("FAIL shl_we: got %b expected %b", we, 4'b0111); end
    tick();
    checks++; if (gpr[0] !== 8'h00) begin errors++; $display("FAIL add_r0: got %h expected 00", gpr[0]); end
    checks++; if (gpr[3] !== 8'hE0) begin errors++; $display("FAIL shl_r3: got %h expected e0", gpr[3]); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[8'h00] = 8'h60; imem[8'h01] = 8'h00;
    imem[8'h02] = 8'h70; imem[8'h03] = 8'h40;
    do_reset();
    ticks(6);
    checks++; if (imem_addr !== 8'h40) begin errors++; $display("FAIL bz_taken: got %h expected 40", imem_addr); end

    imem[8'h01] = 8'h01;
    do_reset();
    ticks(6);
    checks++; if (imem_addr !== 8'h04) begin errors++; $display("FAIL bz_not_taken: got %h expected 04", imem_addr); end

    imem[8'h01] = 8'h80;
    imem[8'h02] = 8'h80; imem[8'h03] = 8'h30;
    do_reset();
    ticks(6);
    checks++; if (imem_addr !== 8'h30) begin errors++; $display("FAIL bn_taken: got %h expected 30", imem_addr); end

    clear_imem();
    imem[8'h00] = 8'h60; imem[8'h01] = 8'h01;
    imem[8'h02] = 8'h90; imem[8'h03] = 8'hFE;
    imem[8'hFE] = 8'h70; imem[8'hFF] = 8'h33;
    do_reset();
    ticks(6);
    checks++; if (imem_addr !== 8'hFE) begin errors++; $display("FAIL br_target: got %h expected fe", imem_addr); end
    ticks(3);
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h expected 00", imem_addr); end
  endtask

  task automatic test_call_ret();
    clear_imem();
    imem[8'h00] = 8'h90; imem[8'h01] = 8'h10;
    imem[8'h10] = 8'hA0; imem[8'h11] = 8'h20;
    imem[8'h20] = 8'hB0;
    do_reset();
    ticks(5);
    checks++; if (we !== 4'b1000) begin errors++; $display("FAIL call_we: got %b expected %b", we, 4'b1000); end
    checks++; if (LRin !== 8'h12) begin errors++; $display("FAIL call_lrin: got %h expected 12", LRin); end
    tick();
    checks++; if (imem_addr !== 8'h20) begin errors++; $display("FAIL call_target: got %h expected 20", imem_addr); end
    checks++; if (we !== 4'b0000) begin errors++; $display("FAIL call_we_after: got %b expected 0000", we); end
    ticks(2);
    checks++; if (imem_addr !== 8'h12) begin errors++; $display("FAIL ret_target: got %h expected 12", imem_addr); end
    ticks(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL call_halted: got %b expected 1", halted); end
  endtask

  task automatic test_out_stall();
    clear_imem();
    imem[8'h00] = 8'h6C; imem[8'h01] = 8'hA5;
    imem[8'h02] = 8'hDC;
    imem[8'h03] = 8'hDC;
    do_reset();
    ticks(4);
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_exec: got %b expected 0", io.out_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid_hold%0d: got %b expected 1", i, io.out_valid); end
      checks++; if (io.out_data !== 8'hA5) begin errors++; $display("FAIL out_data_hold%0d: got %h expected a5", i, io.out_data); end
      if (i == 3) io.out_ready = 1'b1;
      tick();
    end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_drop: got %b expected 0", io.out_valid); end
    checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL out_pc: got %h expected 03", imem_addr); end
    ticks(2);
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL out_ready_entry_valid: got %b expected 1", io.out_valid); end
    tick();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL out_ready_entry_done: got %b expected 0", io.out_valid); end
    io.out_ready = 1'b0;
  endtask

  task automatic test_in_reset_halt();
    clear_imem();
    imem[8'h00] = 8'h60; imem[8'h01] = 8'h77;
    imem[8'h02] = 8'hC0;
    imem[8'h03] = 8'hF0;
    do_reset();
    ticks(5);
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_wait: got %b expected 1", io.in_ready); end
    checks++; if (we !== 4'b0000) begin errors++; $display("FAIL in_we_idle: got %b expected 0000", we); end
    tick();
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_hold: got %b expected 1", io.in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready: got %b expected 0", io.in_ready); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL async_pc: got %h expected 00", imem_addr); end
    io.in_valid = 1'b1;
    io.in_data  = 8'h3C;
    #1;
    checks++; if (we !== 4'b0000) begin errors++; $display("FAIL async_we: got %b expected 0000", we); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (gpr[0] !== 8'h77) begin errors++; $display("FAIL abandoned_in_r0: got %h expected 77", gpr[0]); end
    ticks(5);
    checks++; if (we !== 4'b0001) begin errors++; $display("FAIL in_we: got %b expected 0001", we); end
    checks++; if (wb[7:0] !== 8'h3C) begin errors++; $display("FAIL in_wb: got %h expected 3c", wb[7:0]); end
    tick();
    io.in_valid = 1'b0;
    checks++; if (gpr[0] !== 8'h3C) begin errors++; $display("FAIL in_r0: got %h expected 3c", gpr[0]); end
    checks++; if (zf !== 1'b0) begin errors++; $display("FAIL in_flags: got %b expected 0", zf); end
    checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL in_pc: got %h expected 03", imem_addr); end
    ticks(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted: got %b expected 1", halted); end
    checks++; if (imem_addr !== 8'h04) begin errors++; $display("FAIL halt_pc: got %h expected 04", imem_addr); end
    ticks(3);
    checks++; if (imem_addr !== 8'h04) begin errors++; $display("FAIL halt_frozen: got %h expected 04", imem_addr); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_stays: got %b expected 1", halted); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sub_zero();
    test_alu();
    test_branch();
    test_call_ret();
    test_out_stall();
    test_in_reset_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/execute sequencer for the 8-bit datapath, sitting directly upstream of the 4×8 register file. It fetches 8-bit instructions from a combinational instruction memory and drives the register file's `ra`, `rb`, `wb[9:0]`, `we[3:0]` and `LRin`. It reads back `raVal`, `rbVal`, `N`, `Z` and `LRout`. An internal ALU, branch logic and a valid/ready I/O port complete the core's control path.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk`  in  1  single system clock. The register file samples GPR/flag writes on its falling edge and LR on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  8  instruction address (= `pc`).
- `imem_data`  in  8  instruction byte, combinational from `imem_addr`.
- `ra`, `rb`  out  2 each  register file select. Always `ir[3:2]` and `ir[1:0]`.
- `wb`  out  10  write-back bus: `[9]` Z, `[8]` N, `[7:0]` data.
- `we`  out  4  write enables: `[0]` GPR `mem[ra]`, `[1]` Z, `[2]` N, `[3]` LR.
- `LRin`  out  8  link value.
- `raVal`, `rbVal`  in  8 each  register file read data.
- `N`, `Z`, `LRout`  in  1/1/8  register file flags and link register.
- `in_data`  in  8, `in_valid`  in  1, `in_ready`  out  1  input port.
- `out_data`  out  8, `out_valid`  out  1, `out_ready`  in  1  output port.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: `[7:4]` opcode, `[3:2]` ra (destination), `[1:0]` rb. Two-word opcodes take an immediate byte `imm` from the next address.
- Opcodes:
  - 0 NOP.
  - 1 ADD: ra = ra+rb.
  - 2 SUB: ra = ra−rb.
  - 3 NAND.
  - 4 SHL: ra = ra<<1, zero fill.
  - 5 MOV: ra = rb.
  - 6 LDI: ra = imm (2-word).
  - 7 BZ imm and 8 BN imm (2-word): taken if `Z`/`N` is high.
  - 9 BR imm (2-word).
  - 10 CALL imm (2-word): LR = address after imm, pc = imm.
  - 11 RET: pc = `LRout`.
  - 12 IN: ra = `in_data`.
  - 13 OUT: port = `raVal`.
  - 14 reserved, executes as NOP.
  - 15 HALT.
- States:
  - FETCH: `ir` <= `imem_data`, pc++. Goes to IMM for 2-word opcodes, otherwise EXEC.
  - IMM: `imm` <= `imem_data`, pc++, then EXEC.
  - EXEC: goes to IN_WAIT for IN, OUT_WAIT for OUT, HALT for HALT, otherwise FETCH.
  - IN_WAIT: holds `in_ready`=1.
  - OUT_WAIT: holds `out_valid`=1.
  - HALT: terminal until reset.
- Arithmetic: all results are 8-bit modulo 2^8; carry and borrow are discarded. `wb[8]`=result[7], `wb[9]`=(result==0).
- Write enables:
  - ADD/SUB/NAND/SHL/MOV/LDI: `we`=4'b0111 in EXEC.
  - IN: `we`=4'b0001, only in the IN_WAIT cycle where `in_valid`=1. Flags are untouched.
  - CALL: `we`=4'b1000 with `LRin`=pc in EXEC.
  - All other cycles and states: `we`=0.
- `we` and `wb` are decoded from registered state, `ir` and `imm` only. They are stable across the falling edge inside the cycle.
- Branches: pc <= imm in EXEC when taken. Otherwise pc is already past imm.
- PC wraps 8'hFF→8'h00, including a two-word fetch straddling 8'hFF.

## Timing
- Reset values: state FETCH, pc=`RESET_PC`, `ir`=0, `imm`=0, `we`=0, `wb`=0, `LRin`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `halted`=0.
- Register file contents are not reset by this block.
- Latency:
  - One-word non-I/O instructions: 2 cycles.
  - Two-word instructions: 3 cycles.
  - IN: 3 cycles + waiting cycles.
  - OUT: 3 cycles + stall.
- IN: `in_ready` is high throughout IN_WAIT. The transfer happens on the edge where `in_valid`&&`in_ready`. The GPR write occurs on that cycle's falling edge, and the next state is FETCH.
- OUT: `out_data` is latched from `raVal` on the EXEC→OUT_WAIT edge. `out_valid` stays high and `out_data` stable until the edge where `out_ready`=1, then the next state is FETCH. `out_ready` high on entry completes after exactly 1 wait cycle.
- The LR write (posedge) at the end of CALL's EXEC cycle is visible to a RET that executes later.
- Reset asserted in any state, including mid-handshake: outputs return to reset values immediately (asynchronous). Any pending transfer is abandoned and no write enable is issued.

## Structure
- Package `seq_pkg` holds:
  - opcode localparams `OP_NOP`…`OP_HALT`;
  - state encoding `S_FETCH`, `S_IMM`, `S_EXEC`, `S_IN_WAIT`, `S_OUT_WAIT`, `S_HALT`;
  - the `is_two_word(opcode)` function.
- Sub-module `seq_alu` is purely combinational: op, a, b → 10-bit `{Z,N,result}`. It is instantiated once.

## Test plan
- LDI r1,8'h05; LDI r2,8'h05; SUB r1,r2 → SUB EXEC shows `wb`=10'h200, `we`=4'b0111; r1=0, `Z`=1.
- ADD 8'hFF+8'h01 → `wb`=10'h200 (wrap, carry dropped). NAND 8'h0F,8'hF0 → `wb`=10'h1FF.
- BZ 8'h40 with `Z`=1 → next `imem_addr`=8'h40. With `Z`=0 → fall-through to pc+2.
- CALL 8'h20 at address 8'h10 → `we`=4'b1000, `LRin`=8'h12. A later RET fetches from 8'h12.
- OUT r3 (r3=8'hA5) with `out_ready` low for 3 cycles → `out_valid`=1 and `out_data`=8'hA5 held 4 cycles, dropping after the `out_ready` edge.
- IN r0 waiting on `in_valid`; pulse `rst` mid-wait → `in_ready`=0, `we`=0, pc=`RESET_PC` immediately. HALT afterwards → `halted`=1 and `imem_addr` frozen.
